// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, image-window geometry and pipeline flag bundle
// for the VGA scan-out path.
package vga_pkg;

  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] H_FP    = 10'd16;
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_BP    = 10'd48;
  localparam logic [9:0] H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] V_FP    = 10'd10;
  localparam logic [9:0] V_SYNC  = 10'd2;
  localparam logic [9:0] V_BP    = 10'd33;
  localparam logic [9:0] V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_SYNC_START = H_VIS + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] V_SYNC_START = V_VIS + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  // 128x120 source image, each pixel replicated 4x4, centred horizontally
  localparam int         SCALE_SHIFT  = 2;
  localparam logic [9:0] WIN_H_START  = 10'd64;
  localparam logic [9:0] WIN_H_END    = 10'd576;
  localparam logic [9:0] WIN_V_START  = 10'd0;
  localparam logic [9:0] WIN_V_END    = 10'd480;

  typedef struct packed {
    logic visible;
    logic in_window;
    logic hsync;
    logic vsync;
    logic frame_start;
  } vga_flags_t;

  localparam vga_flags_t FLAGS_IDLE = '{visible: 1'b0, in_window: 1'b0, hsync: 1'b1,
                                        vsync: 1'b1, frame_start: 1'b0};

  // Half-open range test [lo, hi)
  function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Stage 0 of the scan-out pipeline: free-running pixel/line counters and the
// combinational position flags derived from them.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       visible,
  output logic       in_window,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  logic [9:0] hc_reg, hc_next;
  logic [9:0] vc_reg, vc_next;

  // Compare with >= so a corrupted counter still falls back into range
  always_comb begin
    hc_next = hc_reg + 10'd1;
    vc_next = vc_reg;
    if (hc_reg >= H_TOTAL - 10'd1) begin
      hc_next = '0;
      vc_next = (vc_reg >= V_TOTAL - 10'd1) ? 10'd0 : vc_reg + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_reg <= '0;
      vc_reg <= '0;
    end else begin
      hc_reg <= hc_next;
      vc_reg <= vc_next;
    end
  end

  assign hc          = hc_reg;
  assign vc          = vc_reg;
  assign visible     = (hc_reg < H_VIS) && (vc_reg < V_VIS);
  assign in_window   = in_range(hc_reg, WIN_H_START, WIN_H_END) && (vc_reg < WIN_V_END);
  assign hsync       = !in_range(hc_reg, H_SYNC_START, H_SYNC_END);
  assign vsync       = !in_range(vc_reg, V_SYNC_START, V_SYNC_END);
  assign frame_start = (hc_reg == 10'd0) && (vc_reg == 10'd0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: maps the stage-0 position to a video-memory address, then delays
// the position flags one cycle to meet the memory data and registers all outputs.
module vga_scanout
  import vga_pkg::*;
#(
  parameter logic [15:0] BORDER_RGB = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] vaddr,
  input  logic [15:0] vout,
  output logic        hsync,
  output logic        vsync,
  output logic [4:0]  red,
  output logic [4:0]  green,
  output logic [4:0]  blue,
  output logic        active,
  output logic        frame_start
);

  logic [9:0] hc, vc;
  vga_flags_t s0_flags;

  vga_timing u_timing (
    .clk         (clk),
    .rst         (rst),
    .hc          (hc),
    .vc          (vc),
    .visible     (s0_flags.visible),
    .in_window   (s0_flags.in_window),
    .hsync       (s0_flags.hsync),
    .vsync       (s0_flags.vsync),
    .frame_start (s0_flags.frame_start)
  );

  // Source column/row: window offset divided by the replication factor
  logic [9:0]                 win_x;
  logic [6:0]                 col, row;
  logic [9-7-SCALE_SHIFT:0]   col_unused_hi, row_unused_hi;
  logic [SCALE_SHIFT-1:0]     col_unused_lo, row_unused_lo;
  logic                       vout_unused;

  assign win_x = hc - WIN_H_START;
  assign {col_unused_hi, col, col_unused_lo} = win_x;
  assign {row_unused_hi, row, row_unused_lo} = vc - WIN_V_START;
  assign vaddr = s0_flags.in_window ? {2'b00, row, col} : 16'h0000;
  assign vout_unused = vout[15];

  vga_flags_t s1_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= FLAGS_IDLE;
    end else begin
      s1_reg <= s0_flags;
    end
  end

  // Channel order in both vout and BORDER_RGB is B at [4:0], G at [9:5], R at [14:10]
  logic [14:0] rgb_next, rgb_reg;
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign rgb_next[gi*5 +: 5] = s1_reg.in_window ? vout[gi*5 +: 5]
                                 : s1_reg.visible   ? BORDER_RGB[gi*5 +: 5]
                                 : 5'd0;
    end
  endgenerate

  logic active_reg, hsync_reg, vsync_reg, frame_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_reg    <= '0;
      active_reg <= 1'b0;
      hsync_reg  <= 1'b1;
      vsync_reg  <= 1'b1;
      frame_reg  <= 1'b0;
    end else begin
      rgb_reg    <= rgb_next;
      active_reg <= s1_reg.visible;
      hsync_reg  <= s1_reg.hsync;
      vsync_reg  <= s1_reg.vsync;
      frame_reg  <= s1_reg.frame_start;
    end
  end

  assign red         = rgb_reg[14:10];
  assign green       = rgb_reg[9:5];
  assign blue        = rgb_reg[4:0];
  assign active      = active_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign frame_start = frame_reg;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout: table of screen positions with expected
// address/outputs, a 2-deep scoreboard queue, pulse counting and reset sequences.
module tb_vga_scanout;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] vaddr, vout;
  logic        hsync, vsync, active, frame_start;
  logic [4:0]  red, green, blue;
  logic        mem_ff;

  always #20 clk = ~clk;

  vga_scanout #(.BORDER_RGB(16'h7FFF)) dut (
    .clk         (clk),
    .rst         (rst),
    .vaddr       (vaddr),
    .vout        (vout),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .active      (active),
    .frame_start (frame_start)
  );

  // Video memory: returns its own address (bit 15 clear), or all-ones on line 200
  always_ff @(posedge clk) vout <= mem_ff ? 16'hFFFF : {1'b0, vaddr[14:0]};

  typedef struct {
    int          hc;
    int          vc;
    logic [15:0] vaddr;
    logic [18:0] outs;   // {r, g, b, active, hsync, vsync, frame_start}
  } vec_t;

  typedef struct {
    bit chk;
    int idx;
  } sb_t;

  vec_t vecs[$];
  int   vec_at[int];
  sb_t  sb_q[$];

  int tests = 0;
  int fails = 0;
  int mdl_hc = 0;
  int mdl_vc = 0;

  bit count_en = 0;
  int fs_cnt, hs_pulses, hs_len, hs_bad, vs_pulses, vs_len, vs_last;
  logic hs_prev, vs_prev;

  task automatic add(input int hc, input int vc, input logic [15:0] va,
                     input logic [4:0] r, input logic [4:0] g, input logic [4:0] b,
                     input logic a, input logic hs, input logic vs, input logic fs);
    vec_t v;
    v.hc = hc; v.vc = vc; v.vaddr = va;
    v.outs = {r, g, b, a, hs, vs, fs};
    vec_at[hc * 1024 + vc] = vecs.size();
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end else begin
      $display("[TB] ok %s = %h", name, got);
    end
  endtask

  task automatic count_pulses();
    if (frame_start) fs_cnt++;
    if (!hsync) begin
      if (hs_prev) hs_pulses++;
      hs_len++;
    end else if (!hs_prev) begin
      if (hs_len != 96) hs_bad++;
      hs_len = 0;
    end
    if (!vsync) begin
      if (vs_prev) vs_pulses++;
      vs_len++;
    end else if (!vs_prev) begin
      vs_last = vs_len;
      vs_len  = 0;
    end
    hs_prev = hsync;
    vs_prev = vsync;
  endtask

  // One clock: look up the stage-0 position, push its expectation, advance the
  // position model, then pop the entry whose outputs are now on the pins.
  task automatic tick();
    sb_t         e;
    int          key;
    logic [18:0] got;
    e.chk  = 1'b0;
    e.idx  = -1;
    key    = mdl_hc * 1024 + mdl_vc;
    mem_ff = (mdl_vc == 200);
    if (!rst && vec_at.exists(key)) begin
      e.chk = 1'b1;
      e.idx = vec_at[key];
      check($sformatf("vaddr(%0d,%0d)", mdl_hc, mdl_vc), {16'h0, vaddr},
            {16'h0, vecs[e.idx].vaddr});
    end
    sb_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      mdl_hc = 0;
      mdl_vc = 0;
    end else if (mdl_hc == 799) begin
      mdl_hc = 0;
      mdl_vc = (mdl_vc == 524) ? 0 : mdl_vc + 1;
    end else begin
      mdl_hc++;
    end
    @(negedge clk);
    if (sb_q.size() >= 2) begin
      e = sb_q.pop_front();
      if (e.chk) begin
        got = {red, green, blue, active, hsync, vsync, frame_start};
        check($sformatf("outs(%0d,%0d)", vecs[e.idx].hc, vecs[e.idx].vc),
              {13'h0, got}, {13'h0, vecs[e.idx].outs});
      end
    end
    if (count_en) count_pulses();
  endtask

  localparam logic [4:0] W = 5'h1F;

  initial begin
    //   hc   vc   vaddr     r      g      b    act hs vs fs
    add(  0,   0, 16'h0000, W,     W,     W,     1, 1, 1, 1);
    add(  0,   1, 16'h0000, W,     W,     W,     1, 1, 1, 0);
    add( 63,   0, 16'h0000, W,     W,     W,     1, 1, 1, 0);
    add( 64,   0, 16'h0000, 5'h00, 5'h00, 5'h00, 1, 1, 1, 0);
    add( 64,   8, 16'h0100, 5'h00, 5'h08, 5'h00, 1, 1, 1, 0);
    add( 65,   8, 16'h0100, 5'h00, 5'h08, 5'h00, 1, 1, 1, 0);
    add( 66,   8, 16'h0100, 5'h00, 5'h08, 5'h00, 1, 1, 1, 0);
    add( 67,   8, 16'h0100, 5'h00, 5'h08, 5'h00, 1, 1, 1, 0);
    add( 68,   8, 16'h0101, 5'h00, 5'h08, 5'h01, 1, 1, 1, 0);
    add(575,  10, 16'h017F, 5'h00, 5'h0B, 5'h1F, 1, 1, 1, 0);
    add(576,  10, 16'h0000, W,     W,     W,     1, 1, 1, 0);
    add(799,  10, 16'h0000, 5'h00, 5'h00, 5'h00, 0, 1, 1, 0);
    add(  0,  11, 16'h0000, W,     W,     W,     1, 1, 1, 0);
    add( 64,  12, 16'h0180, 5'h00, 5'h0C, 5'h00, 1, 1, 1, 0);
    add( 10, 100, 16'h0000, W,     W,     W,     1, 1, 1, 0);
    add(639, 100, 16'h0000, W,     W,     W,     1, 1, 1, 0);
    add(640, 100, 16'h0000, 5'h00, 5'h00, 5'h00, 0, 1, 1, 0);
    add(655, 100, 16'h0000, 5'h00, 5'h00, 5'h00, 0, 1, 1, 0);
    add(656, 100, 16'h0000, 5'h00, 5'h00, 5'h00, 0, 0, 1, 0);
    add(700, 100, 16'h0000, 5'h00, 5'h00, 5'h00, 0, 0, 1, 0);
    add(751, 100, 16'h0000, 5'h00, 5'h00, 5'h00, 0, 0, 1, 0);
    add(752, 100, 16'h0000, 5'h00, 5'h00, 5'h00, 0, 1, 1, 0);
    add(100, 199, 16'h1889, 5'h06, 5'h04, 5'h09, 1, 1, 1, 0);
    add(100, 200, 16'h1909, W,     W,     W,     1, 1, 1, 0);
    add(100, 201, 16'h1909, 5'h06, 5'h08, 5'h09, 1, 1, 1, 0);
    add(100, 479, 16'h3B89, 5'h0E, 5'h1C, 5'h09, 1, 1, 1, 0);
    add(575, 479, 16'h3BFF, 5'h0E, 5'h1F, 5'h1F, 1, 1, 1, 0);
    add(100, 480, 16'h0000, 5'h00, 5'h00, 5'h00, 0, 1, 1, 0);
    add(100, 489, 16'h0000, 5'h00, 5'h00, 5'h00, 0, 1, 1, 0);
    add(100, 490, 16'h0000, 5'h00, 5'h00, 5'h00, 0, 1, 0, 0);
    add(660, 490, 16'h0000, 5'h00, 5'h00, 5'h00, 0, 0, 0, 0);
    add(100, 491, 16'h0000, 5'h00, 5'h00, 5'h00, 0, 1, 0, 0);
    add(100, 492, 16'h0000, 5'h00, 5'h00, 5'h00, 0, 1, 1, 0);
    add(799, 524, 16'h0000, 5'h00, 5'h00, 5'h00, 0, 1, 1, 0);

    rst    = 1'b1;
    mem_ff = 1'b0;
    repeat (2) @(negedge clk);
    repeat (3) tick();

    check("rst_hsync",  {31'h0, hsync},       32'h1);
    check("rst_vsync",  {31'h0, vsync},       32'h1);
    check("rst_active", {31'h0, active},      32'h0);
    check("rst_colour", {17'h0, red, green, blue}, 32'h0);
    check("rst_frame",  {31'h0, frame_start}, 32'h0);
    check("rst_vaddr",  {16'h0, vaddr},       32'h0);

    // Release: (0,0) reaches the pins after two edges
    rst = 1'b0;
    tick();
    check("rel_frame_e0", {31'h0, frame_start}, 32'h0);
    tick();
    check("rel_frame_e1", {31'h0, frame_start}, 32'h1);

    for (int n = 0; n < 400000 && !(mdl_hc == 700 && mdl_vc == 491); n++) tick();

    // Mid-frame reset while both syncs are asserted
    check("pre_rst_hsync", {31'h0, hsync}, 32'h0);
    check("pre_rst_vsync", {31'h0, vsync}, 32'h0);
    rst = 1'b1;
    sb_q.delete();
    tick();
    check("mid_rst_hsync",  {31'h0, hsync}, 32'h1);
    check("mid_rst_vsync",  {31'h0, vsync}, 32'h1);
    check("mid_rst_colour", {17'h0, red, green, blue}, 32'h0);
    check("mid_rst_active", {31'h0, active}, 32'h0);
    rst = 1'b0;
    tick();
    check("re_rel_frame_e0", {31'h0, frame_start}, 32'h0);
    check("re_rel_hsync_e0", {31'h0, hsync},       32'h1);

    // Count one full frame of outputs, positions 0 .. 419999
    fs_cnt = 0; hs_pulses = 0; hs_len = 0; hs_bad = 0;
    vs_pulses = 0; vs_len = 0; vs_last = 0;
    hs_prev = 1'b1; vs_prev = 1'b1;
    count_en = 1'b1;
    tick();
    check("re_rel_frame_e1", {31'h0, frame_start}, 32'h1);
    repeat (419999) tick();
    count_en = 1'b0;
    check("pre_wrap_frame", {31'h0, frame_start}, 32'h0);
    tick();
    check("wrap_frame", {31'h0, frame_start}, 32'h1);

    check("frame_starts",  fs_cnt,    32'd1);
    check("hsync_pulses",  hs_pulses, 32'd525);
    check("hsync_bad_len", hs_bad,    32'd0);
    check("vsync_pulses",  vs_pulses, 32'd1);
    check("vsync_len",     vs_last,   32'd1600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
